rv32_dmem_responder: RTL and testbench

RV32_DMEM_RESPONDER -- requirements
Module: rv32_dmem_responder

---
 rtl/rv32_mem_pkg.sv | 16 +
 rtl/rv32_dmem_responder_if.sv | 32 +++
 rtl/rv32_dmem_array.sv | 31 +++
 rtl/rv32_dmem_responder.sv | 107 ++++++++++
 tb/tb_rv32_dmem_responder.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared types and field widths for the RV32 data-memory responder.
// Holds the control FSM state encoding and the request/response bus widths.
package rv32_mem_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MASK_W     = 4;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rv32_dmem_responder_if.sv
// Request/response bus between an RV32 load/store initiator and the data memory.
// Both channels use valid/ready: a beat transfers on a rising edge where valid and
// ready are both high; the sender keeps valid and its payload stable until then.
interface rv32_dmem_responder_if (
    input logic clk
);
    import rv32_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_fault;

    modport master (
        input  clk,
        output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  clk,
        input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );

endinterface

// File: rtl/rv32_dmem_array.sv
// Single-port word RAM with per-byte write enables.
// Writes land on the rising edge; the read port is combinational on the same address.
module rv32_dmem_array
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic              we_i,
    input  logic [MASK_W-1:0] wmask_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (wmask_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/rv32_dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, commits stores at accept,
// then presents the response after WAIT_STATES extra cycles and holds it until taken.
module rv32_dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_write_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [DATA_W-1:0] req_wdata_in,
    input  logic [MASK_W-1:0] req_wmask_in,
    output logic              resp_valid_out,
    input  logic              resp_ready_in,
    output logic [DATA_W-1:0] resp_rdata_out,
    output logic              resp_fault_out,
    output state_t            dbg_state_out
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // Span kept one bit wider so a window ending at 2^32 still compares correctly.
    localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH_WORDS) << 2;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

    state_t                state_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  fault_q;

    logic [ADDR_W-1:0] addr_off;
    logic              in_range;
    logic              req_fault;
    logic              accept;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Offset is only trusted when the address is at or above the base, so
    // addresses below BASE_ADDR cannot wrap into the window.
    assign addr_off  = req_addr_in - BASE_ADDR;
    assign in_range  = (req_addr_in >= BASE_ADDR) && ({1'b0, addr_off} < SPAN);
    assign req_fault = (req_addr_in[1:0] != 2'b00) || !in_range;
    assign accept    = (state_q == ST_IDLE) && req_valid_in;
    assign mem_we    = accept && req_write_in && !req_fault && !reset;

    rv32_dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .addr_i  (addr_off[IDX_W+1:2]),
        .we_i    (mem_we),
        .wmask_i (req_wmask_in),
        .wdata_i (req_wdata_in),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rdata_q <= (req_fault || req_write_in) ? '0 : mem_rdata;
                        fault_q <= req_fault;
                        if (WAIT_STATES == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            wait_cnt_q <= WAIT_LOAD;
                            state_q    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_in) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_out  = (state_q == ST_IDLE);
    assign resp_valid_out = (state_q == ST_RESP);
    assign resp_rdata_out = rdata_q;
    assign resp_fault_out = fault_q;
    assign dbg_state_out  = state_q;

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Bench for rv32_dmem_responder: one instance with one wait state at base 0, one with
// zero wait states at base 0x1000, both checked against a byte-level memory model.
module tb_rv32_dmem_responder;
    import rv32_mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rv32_dmem_responder_if if1 (.clk(clk));
    rv32_dmem_responder_if if0 (.clk(clk));
    state_t dbg1, dbg0;

    rv32_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(if1.req_valid), .req_ready_out(if1.req_ready), .req_write_in(if1.req_write),
        .req_addr_in(if1.req_addr), .req_wdata_in(if1.req_wdata), .req_wmask_in(if1.req_wmask),
        .resp_valid_out(if1.resp_valid), .resp_ready_in(if1.resp_ready),
        .resp_rdata_out(if1.resp_rdata), .resp_fault_out(if1.resp_fault), .dbg_state_out(dbg1)
    );

    rv32_dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid_in(if0.req_valid), .req_ready_out(if0.req_ready), .req_write_in(if0.req_write),
        .req_addr_in(if0.req_addr), .req_wdata_in(if0.req_wdata), .req_wmask_in(if0.req_wmask),
        .resp_valid_out(if0.resp_valid), .resp_ready_in(if0.resp_ready),
        .resp_rdata_out(if0.resp_rdata), .resp_fault_out(if0.resp_fault), .dbg_state_out(dbg0)
    );

    int tests_run = 0;
    int fails = 0;

    // Reference memories, word index -> contents (sel 0: dut, sel 1: dut0)
    logic [31:0] m1 [int];
    logic [31:0] m0 [int];
    logic [31:0] exp_q [$];
    bit          exp_f_q [$];

    logic [31:0] rd;
    bit          flt, st, bz, ok;
    int          lat;

    // Reference: fault from plain wide arithmetic, then byte-lane merge into the model.
    function automatic void model_op(input bit sel, input bit wr, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] mask,
                                     output logic [31:0] rdata, output bit fault);
        longint base, span, a;
        int idx;
        logic [31:0] w;
        base  = sel ? 64'd4096 : 64'd0;
        span  = sel ? 64'd1024 : 64'd4096;
        a     = {32'd0, addr};
        fault = (a % 4 != 0) || (a < base) || (a >= base + span);
        rdata = '0;
        if (!fault) begin
            idx = int'((a - base) / 4);
            if (sel) w = m0.exists(idx) ? m0[idx] : 32'h0;
            else     w = m1.exists(idx) ? m1[idx] : 32'h0;
            if (wr) begin
                for (int b = 0; b < 4; b++) if (mask[b]) w[8*b +: 8] = wdata[8*b +: 8];
                if (sel) m0[idx] = w; else m1[idx] = w;
            end else begin
                rdata = w;
            end
        end
    endfunction

    task automatic drive_noise(input logic [31:0] naddr);
        if1.req_valid = 1'b1;
        if1.req_write = 1'b1;
        if1.req_addr  = naddr;
        if1.req_wdata = $urandom;
        if1.req_wmask = 4'hF;
    endtask

    // One transaction on dut; optionally keeps a bogus store request valid while busy.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input int hold, input bit noisy,
                       input logic [31:0] naddr, output logic [31:0] rdata, output bit fault,
                       output int lat_o, output bit stable, output bit busy_ok, output bit ok_o);
        int guard;
        guard = 0;
        rdata = '0; fault = 1'b0; lat_o = 0; stable = 1'b0; busy_ok = 1'b0; ok_o = 1'b0;
        if1.req_valid = 1'b1; if1.req_write = wr; if1.req_addr = addr;
        if1.req_wdata = wdata; if1.req_wmask = mask;
        while (!if1.req_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!if1.req_ready) begin if1.req_valid = 1'b0; return; end
        @(posedge clk); @(negedge clk);
        if (noisy) drive_noise(naddr); else if1.req_valid = 1'b0;
        lat_o = 1; busy_ok = 1'b1;
        while (!if1.resp_valid && lat_o < 40) begin
            if (if1.req_ready) busy_ok = 1'b0;
            @(negedge clk); lat_o++;
            if (noisy) drive_noise(naddr);
        end
        if (!if1.resp_valid) begin if1.req_valid = 1'b0; return; end
        if (if1.req_ready) busy_ok = 1'b0;
        rdata = if1.resp_rdata; fault = if1.resp_fault; stable = 1'b1; ok_o = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (noisy) drive_noise(naddr);
            if (if1.resp_rdata !== rdata || if1.resp_fault !== fault || if1.resp_valid !== 1'b1) stable = 1'b0;
            if (if1.req_ready !== 1'b0) busy_ok = 1'b0;
        end
        if1.resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        if1.resp_ready = 1'b0; if1.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (if1.req_ready !== 1'b1 || if1.resp_valid !== 1'b0 || dbg1 !== ST_IDLE) begin
            fails++; $display("FAIL reset_hs got ready=%b valid=%b state=%0d want 1 0 0", if1.req_ready, if1.resp_valid, dbg1); end
        tests_run++; if (if1.resp_rdata !== 32'h0 || if1.resp_fault !== 1'b0) begin
            fails++; $display("FAIL reset_resp got rdata=%h fault=%b want 0 0", if1.resp_rdata, if1.resp_fault); end
        tests_run++; if (if0.req_ready !== 1'b1 || if0.resp_valid !== 1'b0 || if0.resp_rdata !== 32'h0) begin
            fails++; $display("FAIL reset_dut0 got ready=%b valid=%b rdata=%h want 1 0 0", if0.req_ready, if0.resp_valid, if0.resp_rdata); end
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] mr; bit mf;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        model_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, mr, mf);
        tests_run++; if (!ok || lat != 2 || flt !== 1'b0 || rd !== 32'h0) begin
            fails++; $display("FAIL store_0x10 got ok=%b lat=%0d fault=%b rdata=%h want 1 2 0 0", ok, lat, flt, rd); end
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        tests_run++; if (!ok || lat != 2) begin
            fails++; $display("FAIL load_0x10_latency got ok=%b lat=%0d want 1 2", ok, lat); end
        tests_run++; if (rd !== 32'hDEADBEEF || flt !== 1'b0) begin
            fails++; $display("FAIL load_0x10 got rdata=%h fault=%b want deadbeef 0", rd, flt); end
        tests_run++; if (bz !== 1'b1) begin
            fails++; $display("FAIL load_0x10_ready_low got busy_ok=%b want 1", bz); end
    endtask

    task automatic test_byte_mask();
        logic [31:0] mr; bit mf;
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        model_op(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, mr, mf);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        model_op(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, mr, mf);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        tests_run++; if (rd !== 32'h11BB33DD || flt !== 1'b0) begin
            fails++; $display("FAIL byte_mask got rdata=%h fault=%b want 11bb33dd 0", rd, flt); end
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        tests_run++; if (rd !== 32'h11BB33DD) begin
            fails++; $display("FAIL zero_mask got rdata=%h want 11bb33dd", rd); end
    endtask

    task automatic test_faults();
        logic [31:0] fa [4];
        fa[0] = 32'h22; fa[1] = 32'h1000; fa[2] = 32'hFFFF_FFFC; fa[3] = 32'h21;
        for (int i = 0; i < 4; i++) begin
            txn(1'b0, fa[i], 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
            tests_run++; if (!ok || flt !== 1'b1 || rd !== 32'h0) begin
                fails++; $display("FAIL fault_load_%h got ok=%b fault=%b rdata=%h want 1 1 0", fa[i], ok, flt, rd); end
        end
        txn(1'b1, 32'h22, 32'h00000000, 4'hF, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        tests_run++; if (flt !== 1'b1 || rd !== 32'h0) begin
            fails++; $display("FAIL fault_store got fault=%b rdata=%h want 1 0", flt, rd); end
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        tests_run++; if (rd !== 32'h11BB33DD || flt !== 1'b0) begin
            fails++; $display("FAIL fault_store_no_write got rdata=%h fault=%b want 11bb33dd 0", rd, flt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] mr; bit mf;
        txn(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        model_op(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, mr, mf);
        txn(1'b0, 32'h40, 32'h0, 4'h0, 5, 1'b1, 32'h40, rd, flt, lat, st, bz, ok);
        tests_run++; if (st !== 1'b1 || bz !== 1'b1) begin
            fails++; $display("FAIL backpressure_hold got stable=%b busy_ok=%b want 1 1", st, bz); end
        tests_run++; if (rd !== 32'hCAFEF00D || flt !== 1'b0) begin
            fails++; $display("FAIL backpressure_data got rdata=%h fault=%b want cafef00d 0", rd, flt); end
        tests_run++; if (if1.req_ready !== 1'b1) begin
            fails++; $display("FAIL ready_after_resp got %b want 1", if1.req_ready); end
        txn(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        tests_run++; if (rd !== 32'hCAFEF00D) begin
            fails++; $display("FAIL busy_inputs_ignored got rdata=%h want cafef00d", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] mr; bit mf; bit quiet; int guard;
        // store accepted, reset while waiting
        if1.req_valid = 1'b1; if1.req_write = 1'b1; if1.req_addr = 32'h30;
        if1.req_wdata = 32'h12345678; if1.req_wmask = 4'hF;
        @(posedge clk); @(negedge clk);
        model_op(1'b0, 1'b1, 32'h30, 32'h12345678, 4'hF, mr, mf);
        if1.req_valid = 1'b0; reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        tests_run++; if (if1.req_ready !== 1'b1 || if1.resp_valid !== 1'b0 || dbg1 !== ST_IDLE) begin
            fails++; $display("FAIL reset_in_wait got ready=%b valid=%b state=%0d want 1 0 0", if1.req_ready, if1.resp_valid, dbg1); end
        quiet = 1'b1;
        repeat (4) begin @(negedge clk); if (if1.resp_valid !== 1'b0) quiet = 1'b0; end
        tests_run++; if (!quiet) begin
            fails++; $display("FAIL dropped_resp got resp_valid seen want none"); end
        txn(1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        tests_run++; if (rd !== 32'h12345678 || flt !== 1'b0) begin
            fails++; $display("FAIL store_survives_reset got rdata=%h fault=%b want 12345678 0", rd, flt); end
        // reset while a load response is pending clears the response registers
        if1.req_valid = 1'b1; if1.req_write = 1'b0; if1.req_addr = 32'h30;
        @(posedge clk); @(negedge clk);
        if1.req_valid = 1'b0; guard = 0;
        while (!if1.resp_valid && guard < 20) begin @(negedge clk); guard++; end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        tests_run++; if (if1.resp_valid !== 1'b0 || if1.resp_rdata !== 32'h0 || if1.resp_fault !== 1'b0) begin
            fails++; $display("FAIL reset_in_resp got valid=%b rdata=%h fault=%b want 0 0 0", if1.resp_valid, if1.resp_rdata, if1.resp_fault); end
        // reset wins over an accept in the same cycle
        reset = 1'b1; if1.req_valid = 1'b1; if1.req_write = 1'b1; if1.req_addr = 32'h30;
        if1.req_wdata = 32'hBAD0BAD0; if1.req_wmask = 4'hF;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; if1.req_valid = 1'b0;
        tests_run++; if (if1.req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_vs_accept_state got ready=%b want 1", if1.req_ready); end
        txn(1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
        tests_run++; if (rd !== 32'h12345678) begin
            fails++; $display("FAIL reset_vs_accept_data got rdata=%h want 12345678", rd); end
    endtask

    task automatic test_random();
        logic [31:0] mr, a, wd; bit mf, wr; logic [3:0] mk; int kind;
        for (int k = 0; k < 16; k++) begin
            wd = $urandom;
            txn(1'b1, 32'h100 + 4*k, wd, 4'hF, 0, 1'b0, 32'h0, rd, flt, lat, st, bz, ok);
            model_op(1'b0, 1'b1, 32'h100 + 4*k, wd, 4'hF, mr, mf);
        end
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 6)      a = 32'h100 + 4 * $urandom_range(0, 15);
            else if (kind == 7) a = 32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            else if (kind == 8) a = 32'h1000 + 4 * $urandom_range(0, 1000);
            else                a = 32'hFFFF_FF00 + 4 * $urandom_range(0, 63);
            wr = 1'($urandom_range(0, 1)); wd = $urandom; mk = 4'($urandom_range(0, 15));
            model_op(1'b0, wr, a, wd, mk, mr, mf);
            txn(wr, a, wd, mk, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                32'h100 + 4 * $urandom_range(0, 15), rd, flt, lat, st, bz, ok);
            tests_run++; if (!ok || rd !== mr || flt !== mf || lat != 2) begin
                fails++; $display("FAIL random_%0d wr=%b addr=%h got rdata=%h fault=%b lat=%0d want %h %b 2",
                                  n, wr, a, rd, flt, lat, mr, mf); end
        end
    endtask

    task automatic test_back_to_back();
        logic        ow [12];
        logic [31:0] oa [12], od [12];
        logic [3:0]  om [12];
        int          acc_c [$], rsp_c [$];
        logic [31:0] mr, er; bit mf, ef;
        int idx, cyc, nresp;
        for (int i = 0; i < 4; i++) begin ow[i] = 1'b1; oa[i] = 32'h1000 + 4*i; od[i] = $urandom; om[i] = 4'hF; end
        for (int i = 4; i < 8; i++) begin ow[i] = 1'b0; oa[i] = 32'h1000 + 4 * $urandom_range(0, 3); od[i] = $urandom; om[i] = 4'hF; end
        ow[8] = 1'b0;  oa[8] = 32'h0FFC; od[8] = 0; om[8] = 0;
        ow[9] = 1'b0;  oa[9] = 32'h1400; od[9] = 0; om[9] = 0;
        ow[10] = 1'b1; oa[10] = 32'h1004; od[10] = $urandom; om[10] = 4'($urandom_range(1, 14));
        ow[11] = 1'b0; oa[11] = 32'h1004; od[11] = 0; om[11] = 0;
        for (int i = 0; i < 12; i++) begin
            model_op(1'b1, ow[i], oa[i], od[i], om[i], mr, mf);
            exp_q.push_back(mr); exp_f_q.push_back(mf);
        end
        if0.resp_ready = 1'b1;
        idx = 0; cyc = 0; nresp = 0;
        while (nresp < 12 && cyc < 200) begin
            if (idx < 12) begin
                if0.req_valid = 1'b1; if0.req_write = ow[idx]; if0.req_addr = oa[idx];
                if0.req_wdata = od[idx]; if0.req_wmask = om[idx];
            end else begin
                if0.req_valid = 1'b0;
            end
            if (if0.resp_valid) begin
                er = exp_q.pop_front(); ef = exp_f_q.pop_front();
                rsp_c.push_back(cyc);
                tests_run++; if (if0.resp_rdata !== er || if0.resp_fault !== ef) begin
                    fails++; $display("FAIL b2b_resp_%0d got rdata=%h fault=%b want %h %b", nresp, if0.resp_rdata, if0.resp_fault, er, ef); end
                nresp++;
            end
            if (if0.req_valid && if0.req_ready) begin acc_c.push_back(cyc); idx++; end
            @(posedge clk); cyc++; @(negedge clk);
        end
        if0.req_valid = 1'b0; if0.resp_ready = 1'b0;
        tests_run++; if (nresp != 12 || acc_c.size() != 12) begin
            fails++; $display("FAIL b2b_count got resp=%0d acc=%0d want 12 12", nresp, acc_c.size()); end
        for (int i = 1; i < acc_c.size(); i++) begin
            tests_run++; if (acc_c[i] - acc_c[i-1] != 2) begin
                fails++; $display("FAIL b2b_spacing_%0d got %0d want 2", i, acc_c[i] - acc_c[i-1]); end
        end
        for (int i = 0; i < rsp_c.size() && i < acc_c.size(); i++) begin
            tests_run++; if (rsp_c[i] - acc_c[i] != 1) begin
                fails++; $display("FAIL b2b_latency_%0d got %0d want 1", i, rsp_c[i] - acc_c[i]); end
        end
    endtask

    initial begin
        if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_addr = '0;
        if1.req_wdata = '0; if1.req_wmask = '0; if1.resp_ready = 1'b0;
        if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_addr = '0;
        if0.req_wdata = '0; if0.req_wmask = '0; if0.resp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_store_load();
        test_byte_mask();
        test_faults();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
